// File: rtl/bcd_adder_serial.sv
// Digit-serial packed-BCD adder: processes one decimal digit per clock, least
// significant digit first, and flags any non-BCD operand digit it encounters.
module bcd_adder_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  invalid
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;

    logic [4:0]       w_t;
    logic [4:0]       w_t_adj;
    logic [3:0]       w_dig;
    logic             w_carry;
    logic             w_bad;
    logic [W-1:0]     w_sum_next;

    // The latched operands shift right each digit, so the current digit is always in [3:0].
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_t        = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0, r_carry};
        w_t_adj    = w_t + 5'd6;
        w_carry    = (w_t > 5'd9);
        w_dig      = w_carry ? w_t_adj[3:0] : w_t[3:0];
        w_bad      = (r_a[3:0] > 4'd9) || (r_b[3:0] > 4'd9);
        w_sum_next = sum;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sum_next[i*4 +: 4] = w_dig;
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                        invalid <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    sum     <= w_sum_next;
                    r_carry <= w_carry;
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    if (w_bad) begin
                        invalid <= 1'b1;
                    end
                    if (r_idx == LAST_IDX) begin
                        cout    <= w_carry;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_adder_serial.md
BCD_ADDER_SERIAL -- requirements
Module: bcd_adder_serial

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits per operand; supported values 1..8; W = 4*DIGITS.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  operation request; sampled only in IDLE.
REQ-005 SHALL have port a  input  W  augend, packed BCD, digit 0 in a[3:0].
REQ-006 SHALL have port b  input  W  addend, packed BCD, same packing as a.
REQ-007 SHALL have port cin  input  1  carry-in to digit 0.
REQ-008 SHALL have port sum  output  W  registered BCD result.
REQ-009 SHALL have port cout  output  1  registered carry-out of the top digit.
REQ-010 SHALL have port busy  output  1  high while digits are being processed.
REQ-011 SHALL have port done  output  1  single-cycle completion pulse.
REQ-012 SHALL have port invalid  output  1  high when any latched digit of a or b exceeded 9; registered.

Function
REQ-013 SHALL implement FSM states IDLE, ADD, DONE; all outputs registered.
REQ-014 IDLE with start=1 at an edge: SHALL latch a, b, cin; clear sum, cout, invalid; set digit index to 0; go to ADD.
REQ-015 IDLE with start=0: SHALL hold state and all outputs.
REQ-016 Each ADD edge, digit i: t = a_i + b_i + carry (5-bit, 0..31); if t > 9: sum digit i = (t+6)[3:0], carry = 1; else sum digit i = t[3:0], carry = 0.
REQ-017 Carry into digit 0 SHALL be the latched cin; carry into digit i>0 SHALL be the carry from digit i-1.
REQ-018 Each ADD edge SHALL set invalid if a_i > 9 or b_i > 9; invalid SHALL stay set until the next accepted start or reset.
REQ-019 Invalid digits SHALL still be processed per REQ-016; no other error action is taken.
REQ-020 After processing digit DIGITS-1: SHALL load cout with the final carry and go to DONE.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-022 busy SHALL be 1 exactly while in ADD; done SHALL be 1 exactly while in DONE; the two are never high together.
REQ-023 Latency: start accepted at edge E0; done SHALL be high in the cycle after edge E(DIGITS); start is honoured again at edge E(DIGITS+2).
REQ-024 start SHALL be ignored in ADD and DONE; changes to a, b, cin after E0 SHALL not affect the result.
REQ-025 sum, cout, invalid SHALL hold the result from DONE until the next accepted start.
REQ-026 Upper sum digits not yet processed during ADD SHALL read 0.

Reset
REQ-027 rst=1 SHALL immediately force IDLE; sum=0, cout=0, busy=0, done=0, invalid=0; internal carry and index=0.
REQ-028 rst asserted mid-operation SHALL abort it with no done pulse; after release, the block SHALL accept a new start normally.
REQ-029 start coincident with the first edge after rst release SHALL be accepted.

Verification
REQ-030 DIGITS=4, a=0x1234, b=0x5678, cin=0 -> sum=0x6912, cout=0, invalid=0; done high in the 5th cycle after the start edge.
REQ-031 a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
REQ-032 start re-pulsed during ADD with different operands -> ignored; first result delivered unchanged; exactly one done pulse.
REQ-033 rst pulsed after 2 digits -> all outputs 0 immediately, no done; next op 0x0005+0x0005 -> sum=0x0010, cout=0.
REQ-034 a=0x00A0, b=0x0000, cin=0 -> invalid=1, sum=0x0100 (digit1 t=10 -> 0, carry 1), cout=0; next valid op clears invalid.
REQ-035 Random valid BCD operands and cin (>=1000 ops) checked against a decimal reference model; busy/done exclusivity asserted every cycle.
